// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and constants, including the DRAM responder
// state encoding and its default latency/depth settings.
package cache_pkg;

  localparam int DATA_WIDTH = 32;

  // Load/store unit operation codes seen on the controller's memory side.
  typedef enum logic [2:0] {
    LSU_NOP   = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    LSU_FENCE = 3'd3,
    LSU_FLUSH = 3'd4
  } lsu_ops;

  // DRAM responder handshake states.
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND,
    RELEASE
  } dram_state_t;

  localparam int DRAM_DEPTH_WORDS   = 1024;
  localparam int DRAM_READ_LATENCY  = 4;
  localparam int DRAM_WRITE_LATENCY = 2;

  // True for the operations the backing store actually services.
  function automatic logic is_mem_op(input lsu_ops op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/dram_responder_array.sv
// Single-port synchronous RAM with a registered, enabled read port.
// The read register is reset; the storage itself is never cleared.
module dram_array #(
  parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
  parameter int DEPTH_WORDS = cache_pkg::DRAM_DEPTH_WORDS,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [IW-1:0]         index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Storage write; suppressed while reset is asserted so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[index] <= wdata;
    end
  end

  // Registered read; holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the cache controller's mem_req/mem_ready
// handshake, backed by a word-addressed array with per-op latency.
module dram_responder
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH    = cache_pkg::DATA_WIDTH,
  parameter int DEPTH_WORDS   = cache_pkg::DRAM_DEPTH_WORDS,
  parameter int READ_LATENCY  = cache_pkg::DRAM_READ_LATENCY,
  parameter int WRITE_LATENCY = cache_pkg::DRAM_WRITE_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  lsu_ops                lsu_operator,
  input  logic                  mem_req,
  input  logic [DATA_WIDTH-1:0] write_data_int,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] dram_data_out,
  output logic                  busy
);

  localparam int OFF  = $clog2(DATA_WIDTH / 8);
  localparam int IW   = $clog2(DEPTH_WORDS);
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  dram_state_t           state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx_q, in_idx, ram_idx;
  lsu_ops                op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  accept, rd_en, wr_en, in_single;
  logic                  unused_addr_bits;

  assign in_idx           = address[OFF+IW-1:OFF];
  assign unused_addr_bits = ^address;
  assign in_single        = (lsu_operator == LOAD) ? (READ_LATENCY == 1) : (WRITE_LATENCY == 1);
  assign busy             = (state != IDLE);

  // State, latency counter and request latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      op_q   <= LSU_NOP;
      data_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        idx_q  <= in_idx;
        op_q   <= lsu_operator;
        data_q <= write_data_int;
      end
    end
  end

  // Next state, counter update and RAM control.
  // The read is issued on the edge entering RESPOND so the registered RAM
  // output is the load data during the ready cycle; with unit latency that
  // edge is the acceptance edge, so the live index is used there.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    ram_idx    = idx_q;
    mem_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && is_mem_op(lsu_operator)) begin
          accept   = 1'b1;
          cnt_next = (lsu_operator == LOAD) ? RD_LOAD : WR_LOAD;
          if (in_single) begin
            state_next = RESPOND;
            rd_en      = (lsu_operator == LOAD);
            ram_idx    = in_idx;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = RESPOND;
          rd_en      = (op_q == LOAD);
        end
      end
      RESPOND: begin
        mem_ready  = 1'b1;
        wr_en      = (op_q == STORE);
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!mem_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  dram_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .index (ram_idx),
    .wdata (data_q),
    .rdata (dram_data_out)
  );

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: one default-latency instance and
// one unit-latency instance, directed steps followed by random traffic.
module tb_dram_responder;
  import cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        req_s  [2];
  lsu_ops      op_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] dout_s [2];
  logic        rdy_s  [2];
  logic        busy_s [2];

  dram_responder #(
    .DATA_WIDTH    (32),
    .DEPTH_WORDS   (1024),
    .READ_LATENCY  (4),
    .WRITE_LATENCY (2)
  ) dut (
    .clk (clk), .rst (rst), .address (addr_s[0]), .lsu_operator (op_s[0]),
    .mem_req (req_s[0]), .write_data_int (wd_s[0]), .mem_ready (rdy_s[0]),
    .dram_data_out (dout_s[0]), .busy (busy_s[0])
  );

  dram_responder #(
    .DATA_WIDTH    (32),
    .DEPTH_WORDS   (16),
    .READ_LATENCY  (1),
    .WRITE_LATENCY (1)
  ) dut1 (
    .clk (clk), .rst (rst), .address (addr_s[1]), .lsu_operator (op_s[1]),
    .mem_req (req_s[1]), .write_data_int (wd_s[1]), .mem_ready (rdy_s[1]),
    .dram_data_out (dout_s[1]), .busy (busy_s[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word store keyed by instance and wrapped word index.
  logic [31:0] model [int];
  logic [31:0] last_out [2];
  int          depth [2] = '{1024, 16};
  int          rlat  [2] = '{4, 1};
  int          wlat  [2] = '{2, 1};

  function automatic int key_of(input int w, input logic [31:0] a);
    return w * 100000 + int'((a / 4) % depth[w]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full handshake: request, wait for ready, optional held request,
  // then release and confirm the responder is idle again.
  task automatic access(input int w, input lsu_ops op, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input bit scramble);
    int lat;
    int n;
    bit got;
    lat = (op == LOAD) ? rlat[w] : wlat[w];
    req_s[w] = 1'b1; op_s[w] = op; addr_s[w] = a; wd_s[w] = d;
    got = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      got = rdy_s[w];
      if (scramble && n == 1) begin
        addr_s[w] = $urandom;
        wd_s[w]   = $urandom;
        op_s[w]   = (op == LOAD) ? STORE : LOAD;
      end
      if (got) break;
    end
    check("latency", 32'(n), 32'(lat));
    if (got) begin
      if (op == LOAD) begin
        last_out[w] = model.exists(key_of(w, a)) ? model[key_of(w, a)] : 32'hx;
        check("load_data", dout_s[w], last_out[w]);
      end else begin
        model[key_of(w, a)] = d;
        check("store_dout_held", dout_s[w], last_out[w]);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_no_ready", 32'(rdy_s[w]), 32'd0);
      check("held_busy", 32'(busy_s[w]), 32'd1);
    end
    req_s[w] = 1'b0;
    @(negedge clk);
    check("release_no_ready", 32'(rdy_s[w]), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy_s[w]), 32'd0);
    check("idle_dout", dout_s[w], last_out[w]);
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      req_s[w] = 1'b0; op_s[w] = LSU_NOP; addr_s[w] = '0; wd_s[w] = '0;
      last_out[w] = '0;
    end

    // Reset held with a live request.
    req_s[0] = 1'b1; op_s[0] = STORE; addr_s[0] = 32'h40; wd_s[0] = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", 32'(rdy_s[0]), 32'd0);
      check("rst_busy", 32'(busy_s[0]), 32'd0);
      check("rst_dout", dout_s[0], 32'd0);
      check("rst_dout1", dout_s[1], 32'd0);
    end
    rst = 1'b1;
    access(0, STORE, 32'h40, 32'h1111_1111, 0, 1'b0);

    // Store then load.
    access(0, STORE, 32'h40, 32'hDEAD_BEEF, 0, 1'b0);
    access(0, LOAD,  32'h40, 32'h0, 0, 1'b0);

    // Held request is serviced once.
    access(0, STORE, 32'h44, 32'h1234_5678, 3, 1'b0);
    access(0, LOAD,  32'h44, 32'h0, 3, 1'b0);

    // Aliasing past the array depth.
    access(0, STORE, 32'h1000, 32'h5, 0, 1'b0);
    access(0, LOAD,  32'h0, 32'h0, 0, 1'b0);

    // Reset during a store aborts it.
    access(0, STORE, 32'h80, 32'h0000_0011, 0, 1'b0);
    req_s[0] = 1'b1; op_s[0] = STORE; addr_s[0] = 32'h80; wd_s[0] = 32'hA5;
    @(negedge clk);
    check("abort_access_busy", 32'(busy_s[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(rdy_s[0]), 32'd0);
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    check("abort_dout", dout_s[0], 32'd0);
    last_out[0] = '0;
    last_out[1] = '0;
    rst = 1'b1; req_s[0] = 1'b0;
    @(negedge clk);
    access(0, LOAD, 32'h80, 32'h0, 0, 1'b0);

    // Unit-latency instance, with inputs disturbed after acceptance.
    access(1, STORE, 32'h8, 32'hCAFE_F00D, 0, 1'b1);
    access(1, LOAD,  32'h8, 32'h0, 1, 1'b1);
    access(1, STORE, 32'h48, 32'h0BAD_CAFE, 0, 1'b0);
    access(1, LOAD,  32'h8, 32'h0, 0, 1'b0);

    // Unserviced operation codes never respond.
    req_s[1] = 1'b1; op_s[1] = LSU_FENCE; addr_s[1] = 32'h8;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("nop_ready", 32'(rdy_s[1]), 32'd0);
      check("nop_busy", 32'(busy_s[1]), 32'd0);
      op_s[1] = (c == 1) ? LSU_FLUSH : LSU_NOP;
    end
    req_s[1] = 1'b0;
    @(negedge clk);

    // Random traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      int          w;
      logic [31:0] a;
      lsu_ops      op;
      w  = int'($urandom_range(0, 1));
      a  = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 12);
      op = ($urandom_range(0, 1) == 0) ? STORE : LOAD;
      if (!model.exists(key_of(w, a))) op = STORE;
      access(w, op, a, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
